// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, device-clocked shift, ACK check.
// Latency: INHIBIT_CYCLES+1 cycles of host drive, then paced by the device clock; result after bus idle.
// Backpressure: iSend is taken only in IDLE; requests while oBusy is high are dropped, never queued.
module ps2_host_tx #(
    parameter int FILTER_LEN     = 8,
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iSend,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       oPS2_CLK_OE,
    output logic       oPS2_DATA_OE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYCLES - 1);
    localparam logic [19:0] CNT_MAX  = '1;

    state_t                state;
    state_t                state_nxt;
    logic [FILTER_LEN-1:0] clk_sr;
    logic [FILTER_LEN-1:0] data_sr;
    logic                  clk_f;
    logic                  data_f;
    logic                  clk_f_d;
    logic                  fall_clk;
    // frame[9] = stop, frame[8] = odd parity, frame[7:0] = data (sent LSB first)
    logic [9:0]            frame;
    logic [9:0]            frame_nxt;
    logic [3:0]            idx;
    logic [3:0]            idx_nxt;
    // Shared counter: inhibit duration, then inter-edge timeout. Saturates instead of wrapping.
    logic [19:0]           cnt;
    logic [19:0]           cnt_nxt;
    logic                  data_oe_q;
    logic                  data_oe_nxt;

    // Glitch filters on both lines plus a registered one-cycle falling-edge strobe of the clock
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clk_sr   <= '1;
            data_sr  <= '1;
            clk_f    <= 1'b1;
            data_f   <= 1'b1;
            clk_f_d  <= 1'b1;
            fall_clk <= 1'b0;
        end else begin
            clk_sr  <= {clk_sr[FILTER_LEN-2:0], PS2_CLK_IN};
            data_sr <= {data_sr[FILTER_LEN-2:0], PS2_DATA_IN};
            if (&clk_sr) begin
                clk_f <= 1'b1;
            end else if (~|clk_sr) begin
                clk_f <= 1'b0;
            end
            if (&data_sr) begin
                data_f <= 1'b1;
            end else if (~|data_sr) begin
                data_f <= 1'b0;
            end
            clk_f_d  <= clk_f;
            fall_clk <= clk_f_d & ~clk_f;
        end
    end

    // State, latched frame, bit index, counter and the registered data-line drive
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            frame     <= '0;
            idx       <= '0;
            cnt       <= '0;
            data_oe_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame     <= frame_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            data_oe_q <= data_oe_nxt;
        end
    end

    // Next-state and output decode; line drives come straight from state so reset releases them at once
    always_comb begin
        state_nxt    = state;
        frame_nxt    = frame;
        idx_nxt      = idx;
        cnt_nxt      = (cnt == CNT_MAX) ? cnt : cnt + 20'd1;
        data_oe_nxt  = data_oe_q;
        oBusy        = 1'b0;
        oDone        = 1'b0;
        oError       = 1'b0;
        oPS2_CLK_OE  = 1'b0;
        oPS2_DATA_OE = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt     = '0;
                idx_nxt     = '0;
                data_oe_nxt = 1'b0;
                if (iSend) begin
                    frame_nxt = {1'b1, ~^iData, iData};
                    state_nxt = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                oBusy       = 1'b1;
                oPS2_CLK_OE = 1'b1;
                if (cnt == INH_LAST) begin
                    state_nxt = S_RTS;
                end
            end
            S_RTS: begin
                // Start bit goes out here and stays driven until the first device edge
                oBusy        = 1'b1;
                oPS2_CLK_OE  = 1'b1;
                oPS2_DATA_OE = 1'b1;
                idx_nxt      = '0;
                cnt_nxt      = '0;
                data_oe_nxt  = 1'b1;
                state_nxt    = S_SHIFT;
            end
            S_SHIFT: begin
                oBusy        = 1'b1;
                oPS2_DATA_OE = data_oe_q;
                if (fall_clk) begin
                    cnt_nxt     = '0;
                    data_oe_nxt = ~frame[idx];
                    idx_nxt     = idx + 4'd1;
                    if (idx == 4'd9) begin
                        state_nxt = S_ACK;
                    end
                end else if (cnt == TO_LAST) begin
                    state_nxt = S_FAIL;
                end
            end
            S_ACK: begin
                oBusy        = 1'b1;
                oPS2_DATA_OE = data_oe_q;
                if (fall_clk) begin
                    cnt_nxt   = '0;
                    state_nxt = data_f ? S_FAIL : S_WAIT_IDLE;
                end else if (cnt == TO_LAST) begin
                    state_nxt = S_FAIL;
                end
            end
            S_WAIT_IDLE: begin
                oBusy = 1'b1;
                if (fall_clk) begin
                    cnt_nxt = '0;
                end
                if (clk_f && data_f) begin
                    state_nxt = S_DONE;
                end else if (!fall_clk && cnt == TO_LAST) begin
                    state_nxt = S_FAIL;
                end
            end
            S_DONE: begin
                oDone     = 1'b1;
                state_nxt = S_IDLE;
            end
            S_FAIL: begin
                oError    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Bench for ps2_host_tx: open-drain line model, behavioural PS/2 device, vector table and random frames.
module tb_ps2_host_tx;

    localparam int FL   = 4;
    localparam int INH  = 20;
    localparam int TO   = 200;
    localparam int HALF = 20;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iSend = 1'b0;
    logic       oBusy;
    logic       oDone;
    logic       oError;
    logic       oPS2_CLK_OE;
    logic       oPS2_DATA_OE;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_line;
    logic       ps2_data_line;

    int checks    = 0;
    int passes    = 0;
    int done_seen = 0;
    int err_seen  = 0;

    assign ps2_clk_line  = dev_clk & ~oPS2_CLK_OE;
    assign ps2_data_line = dev_data & ~oPS2_DATA_OE;

    ps2_host_tx #(
        .FILTER_LEN    (FL),
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iData       (iData),
        .iSend       (iSend),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oError      (oError),
        .PS2_CLK_IN  (ps2_clk_line),
        .PS2_DATA_IN (ps2_data_line),
        .oPS2_CLK_OE (oPS2_CLK_OE),
        .oPS2_DATA_OE(oPS2_DATA_OE)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] data;
        bit         ack_low;
        bit         glitch;
        bit         busy_send;
        int         exp_done;
        int         exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge Clock);
        if (oDone) done_seen++;
        if (oError) err_seen++;
        if (oDone || oError) chk("done_err_exclusive", 32'(oDone & oError), 0);
    endtask

    // What the device should see on the data line before its k-th falling clock edge:
    // start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] d);
        iData = d;
        iSend = 1'b1;
        tick();
        iSend = 1'b0;
    endtask

    // Device: waits for request-to-send, then generates nfall clock pulses, sampling data mid-high.
    task automatic device(input int nfall, input bit ack_low, input bit glitch, input bit busy_send,
                          output logic [10:0] smp);
        int n;
        smp = '0;
        n = 0;
        while (!(oPS2_CLK_OE == 1'b0 && oPS2_DATA_OE == 1'b1) && n < 200) begin
            tick();
            n++;
        end
        chk("rts_wait_bound", 32'(n < 200), 1);
        for (int k = 0; k < nfall; k++) begin
            for (int c = 0; c < HALF; c++) begin
                if (c == HALF / 2) begin
                    if (k <= 10) smp[k] = ps2_data_line;
                    if (k == 10) dev_data = ~ack_low;
                    if (glitch && k == 3) dev_clk = 1'b0;
                end
                if (glitch && k == 3 && c == HALF / 2 + 2) dev_clk = 1'b1;
                if (busy_send && k == 5 && c == 0) begin
                    iData = 8'h5A;
                    iSend = 1'b1;
                end
                tick();
                iSend = 1'b0;
            end
            dev_clk = 1'b0;
            for (int c = 0; c < HALF; c++) tick();
            dev_clk = 1'b1;
        end
        for (int c = 0; c < HALF; c++) tick();
        dev_data = 1'b1;
    endtask

    task automatic wait_pulse(input int base);
        int n;
        n = 0;
        while (done_seen + err_seen == base && n < 600) begin
            tick();
            n++;
        end
        chk("result_wait_bound", 32'(n < 600), 1);
    endtask

    task automatic do_frame(input logic [7:0] d, input bit ack_low, input bit glitch, input bit busy_send,
                            output logic [10:0] smp, output int nd, output int ne);
        int d0;
        int e0;
        d0 = done_seen;
        e0 = err_seen;
        send(d);
        chk("busy_after_accept", 32'(oBusy), 1);
        device(11, ack_low, glitch, busy_send, smp);
        wait_pulse(d0 + e0);
        nd = done_seen - d0;
        ne = err_seen - e0;
        chk("busy_low_at_result", 32'(oBusy), 0);
        chk("oe_released_at_result", 32'({oPS2_CLK_OE, oPS2_DATA_OE}), 0);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input bit ack_low,
                               input bit glitch, input bit busy_send, input int edone, input int eerr);
        logic [10:0] smp;
        int nd;
        int ne;
        int d0;
        int e0;
        int any_busy;
        d0 = done_seen;
        e0 = err_seen;
        do_frame(d, ack_low, glitch, busy_send, smp, nd, ne);
        chk({tag, "_bits"}, 32'(smp), 32'(exp_frame(d)));
        chk({tag, "_done"}, 32'(nd), 32'(edone));
        chk({tag, "_err"}, 32'(ne), 32'(eerr));
        any_busy = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (oBusy || oPS2_CLK_OE) any_busy++;
        end
        chk({tag, "_no_extra_frame"}, 32'(any_busy), 0);
        chk({tag, "_pulses_total"}, 32'((done_seen - d0) + (err_seen - e0)), 1);
    endtask

    initial begin
        vec_t        tbl[5];
        logic [10:0] smp;
        int          nd;
        int          ne;
        int          n;
        int          rise_i;
        logic [7:0]  rd;
        bit          ra;

        tbl[0] = '{data: 8'hED, ack_low: 1'b1, glitch: 1'b0, busy_send: 1'b0, exp_done: 1, exp_err: 0};
        tbl[1] = '{data: 8'h00, ack_low: 1'b0, glitch: 1'b0, busy_send: 1'b0, exp_done: 0, exp_err: 1};
        tbl[2] = '{data: 8'hFF, ack_low: 1'b1, glitch: 1'b1, busy_send: 1'b1, exp_done: 1, exp_err: 0};
        tbl[3] = '{data: 8'h01, ack_low: 1'b1, glitch: 1'b0, busy_send: 1'b0, exp_done: 1, exp_err: 0};
        tbl[4] = '{data: 8'h80, ack_low: 1'b0, glitch: 1'b0, busy_send: 1'b0, exp_done: 0, exp_err: 1};

        // Reset state
        repeat (3) @(negedge Clock);
        chk("reset_busy", 32'(oBusy), 0);
        chk("reset_done", 32'(oDone), 0);
        chk("reset_error", 32'(oError), 0);
        chk("reset_clk_oe", 32'(oPS2_CLK_OE), 0);
        chk("reset_data_oe", 32'(oPS2_DATA_OE), 0);
        Reset = 1'b1;
        repeat (10) tick();

        // Inhibit/RTS timing, then timeout with a silent device
        send(8'h3C);
        n = 0;
        rise_i = -1;
        while (oPS2_CLK_OE && n < 100) begin
            if (oPS2_DATA_OE && rise_i < 0) rise_i = n;
            tick();
            n++;
        end
        chk("clk_oe_high_cycles", 32'(n), 32'(INH + 1));
        chk("data_oe_lead", 32'(n - rise_i), 1);
        n = 0;
        while (!oError && n < 400) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'(TO));
        chk("timeout_oe", 32'({oPS2_CLK_OE, oPS2_DATA_OE}), 0);
        chk("timeout_busy", 32'(oBusy), 0);
        tick();
        chk("timeout_pulse_width", 32'(oError), 0);
        repeat (20) tick();

        // Vector table
        for (int i = 0; i < 5; i++) begin
            check_frame($sformatf("vec%0d", i), tbl[i].data, tbl[i].ack_low, tbl[i].glitch,
                        tbl[i].busy_send, tbl[i].exp_done, tbl[i].exp_err);
        end

        // iSend in the DONE cycle is dropped
        do_frame(8'h5B, 1'b1, 1'b0, 1'b0, smp, nd, ne);
        chk("done_cycle_pulse", 32'(oDone), 1);
        iData = 8'h77;
        iSend = 1'b1;
        tick();
        iSend = 1'b0;
        chk("done_cycle_send_idle", 32'(oBusy), 0);
        tick();
        chk("done_cycle_send_dropped_busy", 32'(oBusy), 0);
        chk("done_cycle_send_dropped_clk", 32'(oPS2_CLK_OE), 0);
        repeat (20) tick();

        // Asynchronous reset in the middle of the data bits
        send(8'h00);
        device(4, 1'b1, 1'b0, 1'b0, smp);
        chk("pre_reset_busy", 32'(oBusy), 1);
        chk("pre_reset_data_oe", 32'(oPS2_DATA_OE), 1);
        #2 Reset = 1'b0;
        #1;
        chk("async_reset_oe", 32'({oPS2_CLK_OE, oPS2_DATA_OE}), 0);
        chk("async_reset_busy", 32'(oBusy), 0);
        @(negedge Clock);
        Reset = 1'b1;
        repeat (10) tick();
        check_frame("post_reset", 8'hED, 1'b1, 1'b0, 1'b0, 1, 0);

        // Random frames against the reference model
        for (int r = 0; r < 8; r++) begin
            rd = 8'($urandom);
            ra = 1'($urandom_range(0, 1));
            check_frame($sformatf("rand%0d", r), rd, ra, 1'b0, 1'b0, int'(ra), int'(!ra));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule
